// File: rtl/servo_pwm_array.sv
// servo_pwm_array: multi-channel RC-servo PWM generator with an Avalon-MM register file.
// Define SERVO_PWM_SLEW_EN to include the SLEW register and the per-frame slew limiter.
module servo_pwm_array #(
   parameter int CHANNELS  = 2,
   parameter int CLK_HZ    = 50000000,
   parameter int PERIOD_US = 20000,
   parameter int MIN_US    = 1000,
   parameter int MAX_US    = 2000,
   parameter int CENTER_US = 1500
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          address,
   input  logic                write,
   input  logic [31:0]         writedata,
   input  logic                read,
   output logic [31:0]         readdata,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                frame_start
);
   localparam int DIV = CLK_HZ / 1000000;
   localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
   localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_US - 1);
   localparam logic [15:0] MIN_W = 16'(MIN_US);
   localparam logic [15:0] MAX_W = 16'(MAX_US);
   localparam logic [15:0] CENTER_W = 16'(CENTER_US);

   logic [PW-1:0] psc_q, psc_d;
   logic [15:0] frame_cnt_q, frame_cnt_d, fcount_q, fcount_d, slew_q, slew_d, wclamp;
   logic [CHANNELS-1:0] ctrl_q, ctrl_d, act_en_q, act_en_d, pwm_q, pwm_d;
   logic [15:0] tgt_q [CHANNELS];
   logic [15:0] tgt_d [CHANNELS];
   logic [15:0] cur_q [CHANNELS];
   logic [15:0] cur_d [CHANNELS];
   logic [31:0] readdata_q, readdata_d, rsel;
   logic frame_start_q, frame_start_d, us_tick, boundary;
   logic unused_wdata;

   assign unused_wdata = ^writedata[31:16];
   assign readdata = readdata_q;
   assign pwm_out = pwm_q;
   assign frame_start = frame_start_q;

   // 17-bit difference so the comparison against SLEW cannot wrap
   function automatic logic [15:0] step(input logic [15:0] cur, input logic [15:0] tgt,
                                        input logic [15:0] slew);
      logic [16:0] diff;
      diff = tgt >= cur ? {1'b0, tgt} - {1'b0, cur} : {1'b0, cur} - {1'b0, tgt};
      return (slew == '0 || diff <= {1'b0, slew}) ? tgt : tgt > cur ? cur + slew : cur - slew;
   endfunction

   always_comb begin
      us_tick = psc_q == DIV_LAST;
      boundary = us_tick && frame_cnt_q == PERIOD_LAST;
      psc_d = us_tick ? '0 : psc_q + PW'(1);
      frame_cnt_d = !us_tick ? frame_cnt_q : boundary ? '0 : frame_cnt_q + 16'd1;
      fcount_d = fcount_q + {15'd0, boundary};
      frame_start_d = boundary;
      act_en_d = boundary ? ctrl_q : act_en_q;
      ctrl_d = (write && address == 4'd0) ? writedata[CHANNELS-1:0] : ctrl_q;
`ifdef SERVO_PWM_SLEW_EN
      slew_d = (write && address == 4'd2) ? writedata[15:0] : slew_q;
`else
      slew_d = '0;
`endif
      wclamp = writedata[15:0] < MIN_W ? MIN_W : writedata[15:0] > MAX_W ? MAX_W : writedata[15:0];
      rsel = address == 4'd0 ? 32'(ctrl_q) : address == 4'd1 ? {16'd0, fcount_q} :
             address == 4'd2 ? {16'd0, slew_q} : '0;
      for (int i = 0; i < CHANNELS; i++) begin
         tgt_d[i] = (write && address == 4'(3 + i)) ? wclamp : tgt_q[i];
         cur_d[i] = boundary ? step(cur_q[i], tgt_q[i], slew_q) : cur_q[i];
         pwm_d[i] = act_en_q[i] & (frame_cnt_q < cur_q[i]);
         if (address == 4'(3 + i)) rsel = {cur_q[i], tgt_q[i]};
      end
      readdata_d = read ? rsel : readdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         psc_q <= '0;
         frame_cnt_q <= '0;
         fcount_q <= '0;
         slew_q <= '0;
         ctrl_q <= '0;
         act_en_q <= '0;
         pwm_q <= '0;
         tgt_q <= '{default: CENTER_W};
         cur_q <= '{default: CENTER_W};
         readdata_q <= '0;
         frame_start_q <= 1'b0;
      end else begin
         psc_q <= psc_d;
         frame_cnt_q <= frame_cnt_d;
         fcount_q <= fcount_d;
         slew_q <= slew_d;
         ctrl_q <= ctrl_d;
         act_en_q <= act_en_d;
         pwm_q <= pwm_d;
         tgt_q <= tgt_d;
         cur_q <= cur_d;
         readdata_q <= readdata_d;
         frame_start_q <= frame_start_d;
      end
   end
endmodule

// File: tb/tb_servo_pwm_array.sv
// tb_servo_pwm_array: scoreboard bench for servo_pwm_array at DIV=2 with 100 us frames.
module tb_servo_pwm_array;
   logic clk = 0, reset = 1, write = 0, read = 0;
   logic [3:0] address = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [1:0] pwm_out;
   logic frame_start;
   int checks = 0, errors = 0;
   logic [31:0] exp_rd[$];
   logic [3:0] exp_ra[$];
   int exp_p0[$];
   int exp_p1[$];
   int plen[2];
   int hi_cnt = 0, fs_gap = 0;
   bit fs_seen = 0;
   logic rd_v = 0, rst_s = 1;

   servo_pwm_array #(.CHANNELS(2), .CLK_HZ(2000000), .PERIOD_US(100), .MIN_US(10),
                     .MAX_US(90), .CENTER_US(50)) dut (
      .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
      .read(read), .readdata(readdata), .pwm_out(pwm_out), .frame_start(frame_start));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_done(input int c, input int len);
      int e;
      if ((c == 0 && exp_p0.size() == 0) || (c == 1 && exp_p1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL pwm%0d_pulse: got %0d cycles, expected no pulse", c, len);
      end else begin
         if (c == 0) e = exp_p0.pop_front();
         else e = exp_p1.pop_front();
         chk($sformatf("pwm%0d_width", c), len, e);
      end
   endtask

   always @(posedge clk) begin
      rd_v <= read;
      rst_s <= reset;
   end

   // Monitor: read responses, pulse widths and frame_start spacing
   always @(negedge clk) begin
      if (rd_v) begin
         if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no read", readdata);
         end else chk($sformatf("rd@%0d", exp_ra.pop_front()), readdata, exp_rd.pop_front());
      end
      if (pwm_out != 0) hi_cnt++;
      for (int c = 0; c < 2; c++) begin
         if (pwm_out[c]) plen[c]++;
         else if (plen[c] != 0) begin
            pulse_done(c, plen[c]);
            plen[c] = 0;
         end
      end
      if (rst_s) begin
         fs_seen = 0;
         fs_gap = 0;
      end else if (frame_start) begin
         if (fs_seen) chk("frame_period", fs_gap, 200);
         fs_seen = 1;
         fs_gap = 1;
      end else fs_gap++;
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address = a;
      writedata = d;
      write = 1;
      @(negedge clk);
      write = 0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e);
      exp_ra.push_back(a);
      exp_rd.push_back(e);
      address = a;
      read = 1;
      @(negedge clk);
      read = 0;
   endtask

   task automatic rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
      exp_ra.push_back(a);
      exp_rd.push_back(e);
      address = a;
      writedata = d;
      write = 1;
      read = 1;
      @(negedge clk);
      write = 0;
      read = 0;
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 400);
      if (!frame_start) begin
         checks++;
         errors++;
         $display("FAIL wait_frame: got no frame_start in 400 cycles, expected one");
      end
   endtask

   initial begin
      int hi0;
      repeat (3) @(negedge clk);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_readdata", readdata, 0);
      chk("rst_frame_start", frame_start, 0);
      reset = 0;
      rd(4'd3, 32'h0032_0032);
      rd(4'd0, 32'h0);
      repeat (300) @(negedge clk);
      chk("idle_high_cycles", hi_cnt, 0);
      wait_frame();
      wr(4'd0, 32'd3);
      wr(4'd3, 32'd20);
      wr(4'd4, 32'd200);
      exp_p0.push_back(40); exp_p0.push_back(40);
      exp_p1.push_back(180); exp_p1.push_back(180);
      wait_frame();
      rd(4'd4, 32'h005A_005A);
      rd(4'd3, 32'h0014_0014);
      rd(4'd1, 32'd3);
      wait_frame();
      repeat (10) @(negedge clk);
      wr(4'd3, 32'd70);
      exp_p0.push_back(140);
      exp_p1.push_back(180);
      wait_frame();
      wr(4'd3, 32'd20);
      exp_p0.push_back(40);
      exp_p1.push_back(180);
      wait_frame();
      repeat (10) @(negedge clk);
      wr(4'd0, 32'd0);
      wait_frame();
      hi0 = hi_cnt;
      wait_frame();
      chk("disabled_high_cycles", hi_cnt - hi0, 0);
      wr(4'd3, 32'd50);
      repeat (198) @(negedge clk);
      wr(4'd0, 32'd1);
      chk("boundary_write_align", frame_start, 1);
      rd(4'd0, 32'd1);
      wr(4'd2, 32'd15);
      rw(4'd3, 32'd90, 32'h0032_0032);
`ifdef SERVO_PWM_SLEW_EN
      rd(4'd2, 32'd15);
      exp_p0.push_back(130); exp_p0.push_back(160); exp_p0.push_back(180);
`else
      rd(4'd2, 32'd0);
      exp_p0.push_back(180); exp_p0.push_back(180); exp_p0.push_back(180);
`endif
      wait_frame();
`ifdef SERVO_PWM_SLEW_EN
      rd(4'd3, 32'h0041_005A);
`else
      rd(4'd3, 32'h005A_005A);
`endif
      wait_frame();
      wait_frame();
      wait_frame();
      exp_p0.push_back(10);
      repeat (10) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("pwm_after_reset", pwm_out, 0);
      rd(4'd1, 32'd0);
      rd(4'd15, 32'd0);
      rd(4'd0, 32'd0);
      rd(4'd3, 32'h0032_0032);
      repeat (20) @(negedge clk);
      chk("p0_queue_left", exp_p0.size(), 0);
      chk("p1_queue_left", exp_p1.size(), 0);
      chk("rd_queue_left", exp_rd.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
